// File: rtl/kinase_valve_sequencer.sv
// Assay protocol sequencer for the dual-lane kinase chip: LOAD, MIX, INCUBATE, WASH, COLLECT, then DONE.
// Both lanes share the c/s/p valve lines, so one registered valve image drives both lanes in lockstep.
module kinase_valve_sequencer #(
  parameter int CNT_W       = 16,
  parameter int LOAD_CYC    = 64,
  parameter int PUMP_STEP   = 8,
  parameter int MIX_ROUNDS  = 16,
  parameter int INC_CYC     = 1024,
  parameter int WASH_CYC    = 128,
  parameter int COLLECT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase,
  output logic [12:0] c,
  output logic [3:0]  s,
  output logic [4:0]  p
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MIX      = 3'd2,
    INCUBATE = 3'd3,
    WASH     = 3'd4,
    COLLECT  = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Terminal count for an N-cycle dwell; 0 behaves as 1, oversize values clip to all-ones.
  function automatic logic [CNT_W-1:0] last_of(input int n);
    longint m;
    m = (n < 1) ? 64'sd0 : longint'(n) - 64'sd1;
    if (m >= (longint'(1) << CNT_W)) return '1;
    return m[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] LOAD_LAST  = last_of(LOAD_CYC);
  localparam logic [CNT_W-1:0] STEP_LAST  = last_of(PUMP_STEP);
  localparam logic [CNT_W-1:0] ROUND_LAST = last_of(MIX_ROUNDS);
  localparam logic [CNT_W-1:0] INC_LAST   = last_of(INC_CYC);
  localparam logic [CNT_W-1:0] WASH_LAST  = last_of(WASH_CYC);
  localparam logic [CNT_W-1:0] COLL_LAST  = last_of(COLLECT_CYC);

  // A saturated counter counts as expired so a run can never stall.
  function automatic logic expired(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] last);
    return (cnt == last) || (&cnt);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [2:0] mix_pat(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b101;
      3'd1:    return 3'b100;
      3'd2:    return 3'b110;
      3'd3:    return 3'b010;
      3'd4:    return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  state_t           st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] rnd, rnd_nx;
  logic [2:0]       step, step_nx;
  logic [12:0]      c_nx;
  logic [3:0]       s_nx;
  logic [4:0]       p_nx;

  always_comb begin
    st_nx   = st;
    cnt_nx  = sat_inc(cnt);
    rnd_nx  = rnd;
    step_nx = step;
    case (st)
      IDLE:     if (start) st_nx = LOAD;
      LOAD:     if (expired(cnt, LOAD_LAST)) st_nx = MIX;
      MIX: begin
        if (expired(cnt, STEP_LAST)) begin
          cnt_nx = '0;
          if (step == 3'd5) begin
            step_nx = 3'd0;
            if (expired(rnd, ROUND_LAST)) st_nx = INCUBATE;
            else rnd_nx = sat_inc(rnd);
          end else begin
            step_nx = step + 3'd1;
          end
        end
      end
      INCUBATE: if (expired(cnt, INC_LAST))  st_nx = WASH;
      WASH:     if (expired(cnt, WASH_LAST)) st_nx = COLLECT;
      COLLECT:  if (expired(cnt, COLL_LAST)) st_nx = DONE;
      DONE:     if (ack) st_nx = IDLE;
      default:  st_nx = IDLE;
    endcase
    if (abort) st_nx = IDLE;
    // Every state entry (and any idle/done cycle) starts from clean counters.
    if (abort || st_nx != st || st == IDLE || st == DONE) begin
      cnt_nx  = '0;
      rnd_nx  = '0;
      step_nx = 3'd0;
    end
  end

  // Valve image is decoded from the next state so it lands on the same edge as phase.
  always_comb begin
    c_nx = 13'h1FFF;
    s_nx = 4'hF;
    p_nx = 5'h00;
    case (st_nx)
      LOAD:    begin c_nx = 13'h1FF8; s_nx = 4'h0; end
      MIX:     p_nx = {2'b00, mix_pat(step_nx)};
      WASH:    begin c_nx = 13'h1E3F; s_nx = 4'h0; p_nx = 5'h18; end
      COLLECT: c_nx = 13'h03FF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      rnd  <= '0;
      step <= 3'd0;
      busy <= 1'b0;
      done <= 1'b0;
      c    <= 13'h1FFF;
      s    <= 4'hF;
      p    <= 5'h00;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      rnd  <= rnd_nx;
      step <= step_nx;
      busy <= (st_nx != IDLE) && (st_nx != DONE);
      done <= (st_nx == DONE);
      c    <= c_nx;
      s    <= s_nx;
      p    <= p_nx;
    end
  end

  assign phase = st;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: randomized host noise checked against a timeline model of the assay protocol.
module tb_kinase_valve_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0, ack = 1'b0;
  logic        busy, done;
  logic [2:0]  phase;
  logic [12:0] c;
  logic [3:0]  s;
  logic [4:0]  p;

  logic        start1 = 1'b0, abort1 = 1'b0, ack1 = 1'b0;
  logic        busy1, done1;
  logic [2:0]  phase1;
  logic [12:0] c1;
  logic [3:0]  s1;
  logic [4:0]  p1;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [26:0] IDLE_VEC = {3'd0, 1'b0, 1'b0, 13'h1FFF, 4'hF, 5'h00};

  kinase_valve_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ack(ack),
    .busy(busy), .done(done), .phase(phase), .c(c), .s(s), .p(p)
  );

  kinase_valve_sequencer #(
    .LOAD_CYC(0), .PUMP_STEP(1), .MIX_ROUNDS(1), .INC_CYC(2), .WASH_CYC(1), .COLLECT_CYC(1)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .ack(ack1),
    .busy(busy1), .done(done1), .phase(phase1), .c(c1), .s(s1), .p(p1)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] obs0();
    return {phase, busy, done, c, s, p};
  endfunction

  function automatic logic [26:0] obs1();
    return {phase1, busy1, done1, c1, s1, p1};
  endfunction

  function automatic int mx1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Expected outputs j cycles after the start-accepting edge, from cumulative dwell times.
  function automatic logic [26:0] exp_vec(input int j, input int ld, input int ps, input int mr,
                                          input int ic, input int wc, input int cc);
    int d[5];
    int pat[6];
    int acc, ph, off;
    logic [12:0] ce;
    logic [3:0]  se;
    logic [4:0]  pe;
    pat[0] = 5; pat[1] = 4; pat[2] = 6; pat[3] = 2; pat[4] = 3; pat[5] = 1;
    d[0] = mx1(ld); d[1] = mx1(mr) * 6 * mx1(ps); d[2] = mx1(ic); d[3] = mx1(wc); d[4] = mx1(cc);
    if (j < 0) return IDLE_VEC;
    ph = 6; off = 0; acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (ph == 6 && j < acc + d[k]) begin
        ph = k + 1;
        off = j - acc;
      end
      acc += d[k];
    end
    ce = 13'h1FFF; se = 4'hF; pe = 5'h00;
    case (ph)
      1: begin ce = 13'h1FF8; se = 4'h0; end
      2: pe = 5'(pat[(off / mx1(ps)) % 6]);
      4: begin ce = 13'h1E3F; se = 4'h0; pe = 5'h18; end
      5: ce = 13'h03FF;
      default: ;
    endcase
    return {3'(ph), (ph >= 1 && ph <= 5), (ph == 6), ce, se, pe};
  endfunction

  task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: run to DONE; mode 1: abort at stop_j; mode 2: reset at stop_j.
  task automatic run_main(input int stop_j, input int mode);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 2048; j++) begin
      chk("run", obs0(), exp_vec(j, 64, 8, 16, 1024, 128, 64));
      if (mode != 0 && j == stop_j) break;
      if (j == 2048) break;
      start = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
    ack   = 1'b0;
    if (mode == 1) begin
      abort = 1'b1;
      start = 1'($urandom_range(0, 1));
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_idle", obs0(), IDLE_VEC);
    end else if (mode == 2) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("reset_mid", obs0(), IDLE_VEC);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset", obs0(), IDLE_VEC);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_hold", obs0(), IDLE_VEC);
    end

    run_main(0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold", obs0(), exp_vec(2048, 64, 8, 16, 1024, 128, 64));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", obs0(), IDLE_VEC);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_in_idle", obs0(), IDLE_VEC);

    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("start_abort_idle", obs0(), IDLE_VEC);
    end
    start = 1'b0;
    abort = 1'b0;

    run_main(900, 1);
    run_main(0, 0);
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    chk("start_ack_done", obs0(), IDLE_VEC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_new_run", obs0(), IDLE_VEC);
    end

    run_main(int'($urandom_range(0, 2047)), 1);
    run_main(1900, 2);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j <= 11; j++) begin
      chk("small_run", obs1(), exp_vec(j, 0, 1, 1, 2, 1, 1));
      if (j < 11) tick();
    end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("small_ack", obs1(), IDLE_VEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
